tooth_qualifier: RTL
====================

# tooth_qualifier

Crank-trigger front end sitting between the VR input double-flop synchronizer and the wheel-decoding sync stage. Detects the selected edge of the conditioned VR signal, rejects noise edges with a fixed minimum gap plus an adaptive blanking window scaled from the previous tooth, and measures the tooth period in clock cycles. Emits one qualified-tooth strobe per accepted edge, the measured period, and a stalled-engine flag the sync stage uses to drop sync.

## Interface
- PERIOD_W, 32, width of the period counter and `tooth_period`
- MIN_GAP, 20, minimum cycles between accepted edges (10 us at 2 MHz)
- STALL_TIMEOUT, 2_000_000, cycles without an accepted edge before declaring stall (1 s)

- clk  in  1  system clock, 2 MHz nominal
- reset  in  1  synchronous, active-high
- vr_in  in  1  VR comparator output, already synchronized to clk
- cfg_edge_sel  in  1  0 = rising edge is the tooth, 1 = falling
- cfg_blank_sel  in  2  adaptive blanking: 0 none, 1 period/8, 2 period/4, 3 period/2
- tooth_strobe  out  1  one-cycle pulse per accepted edge
- tooth_period  out  PERIOD_W  cycles between last two accepted edges
- period_valid  out  1  tooth_period holds a real measurement
- stalled  out  1  no valid rotation
- noise_cnt  out  16  count of rejected edges, saturating

## Operation
- Edge detect: register `vr_d`; edge = selected transition between `vr_d` and `vr_in`.
- Gap counter `cnt`: on accepted edge load 1; otherwise increment, saturating at all-ones. Edges N cycles apart give cnt = N at the second edge.
- States: IDLE (reset, stalled), FIRST (one edge seen, no period yet), RUN.
- Threshold: IDLE/FIRST use MIN_GAP. RUN uses max(MIN_GAP, tooth_period >> s), s = 3/2/1 for cfg_blank_sel 1/2/3; sel 0 uses MIN_GAP only.
- Edge accepted when cnt >= threshold. In IDLE the first edge is accepted unconditionally (cnt meaningless).
- IDLE + accepted edge -> FIRST; strobe; period unchanged; stalled stays 1.
- FIRST + accepted edge -> RUN; strobe; tooth_period <= cnt; period_valid <= 1; stalled <= 0.
- RUN + accepted edge -> RUN; strobe; tooth_period <= cnt.
- Rejected edge (any state): no strobe, cnt keeps counting, noise_cnt += 1 saturating at 0xFFFF.
- FIRST/RUN with cnt == STALL_TIMEOUT and no accepted edge -> IDLE; stalled <= 1; period_valid <= 0; tooth_period <= 0.
- Simultaneous accepted edge and timeout: edge wins.
- Non-selected transitions ignored entirely (not counted as noise).
- cfg inputs are used live; a change takes effect on the next cycle's comparison, no state flush.

## Timing
- Reset values: tooth_strobe 0, tooth_period 0, period_valid 0, stalled 1, noise_cnt 0, state IDLE, cnt 0; `vr_d` loads `vr_in` during reset so no spurious edge on release.
- Reset mid-operation: same values next cycle, regardless of state.
- Latency: vr_in transition in cycle t -> tooth_strobe high in cycle t+1, exactly one cycle; tooth_period/period_valid/stalled update in the same cycle t+1.
- tooth_period is stable between strobes; consumers may sample on tooth_strobe.
- Threshold compare uses tooth_period as registered before the current edge.
- Back-to-back accepted edges are impossible (MIN_GAP >= 2 enforced by parameter check).

## Test plan
- Reset, rising edges every 1000 cycles, sel 0, blank 2 -> first strobe stalled=1; second strobe tooth_period=1000, period_valid=1, stalled=0; subsequent strobes 1000; noise_cnt=0.
- RUN at period 1000, blank 2, inject extra edge 200 cycles after a tooth -> no strobe, noise_cnt=1; next real tooth at 1000 -> tooth_period=1000.
- Same glitch with blank 0 -> glitch accepted, tooth_period=200 then 800; glitch at 10 cycles (< MIN_GAP) -> rejected.
- Stop edges after RUN at STALL_TIMEOUT=5000 (bench override) -> 5000 cycles after last tooth stalled=1, period_valid=0, tooth_period=0; next edge gives strobe with stalled still 1.
- cfg_edge_sel=1 with 30%-duty square wave, period 1000 -> strobes one cycle after each falling edge, rising edges ignored, noise_cnt unchanged.
- Assert reset mid-RUN for 1 cycle while vr_in high -> outputs at reset values next cycle, no strobe on release, noise_cnt 0.

Source files
------------

// File: rtl/tooth_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : tooth_qualifier
// Description : Crank VR tooth qualifier. Selected-edge detect, minimum-gap
//               and adaptive blanking noise rejection, tooth period
//               measurement and stall detection.
// Revision    : 1.0 - initial release
// ============================================================================
module tooth_qualifier #(
    parameter int PERIOD_W      = 32,
    parameter int MIN_GAP       = 20,
    parameter int STALL_TIMEOUT = 2_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vr_in,
    input  logic                cfg_edge_sel,
    input  logic [1:0]          cfg_blank_sel,
    output logic                tooth_strobe,
    output logic [PERIOD_W-1:0] tooth_period,
    output logic                period_valid,
    output logic                stalled,
    output logic [15:0]         noise_cnt
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_first = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;

    localparam logic [PERIOD_W-1:0] c_min_gap = PERIOD_W'(MIN_GAP);
    localparam logic [PERIOD_W-1:0] c_timeout = PERIOD_W'(STALL_TIMEOUT);
    localparam logic [PERIOD_W-1:0] c_one     = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] c_cnt_max = {PERIOD_W{1'b1}};

    // A gap below 2 would allow accepted edges on consecutive cycles.
    generate
        if (MIN_GAP < 2) begin : g_min_gap_check
            $error("tooth_qualifier: MIN_GAP must be at least 2");
        end
    endgenerate

    logic [1:0]          r_state;
    logic                r_vr_d;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_strobe;
    logic [PERIOD_W-1:0] r_period;
    logic                r_valid;
    logic                r_stalled;
    logic [15:0]         r_noise;

    logic                w_edge;
    logic [PERIOD_W-1:0] w_blank;
    logic [PERIOD_W-1:0] w_thresh;
    logic                w_accept;
    logic                w_reject;
    logic                w_timeout;
    logic [1:0]          w_state_nxt;
    logic                w_strobe_nxt;
    logic [PERIOD_W-1:0] w_period_nxt;
    logic                w_valid_nxt;
    logic                w_stalled_nxt;

    assign w_edge = cfg_edge_sel ? (r_vr_d & ~vr_in) : (~r_vr_d & vr_in);

    always_comb begin
        w_blank = '0;
        case (cfg_blank_sel)
            2'd1:    w_blank = r_period >> 3;
            2'd2:    w_blank = r_period >> 2;
            2'd3:    w_blank = r_period >> 1;
            default: w_blank = '0;
        endcase
    end

    // Blanking only applies once a real period exists; never below the fixed gap.
    assign w_thresh  = ((r_state == c_st_run) && (w_blank > c_min_gap)) ? w_blank : c_min_gap;
    assign w_accept  = w_edge && ((r_state == c_st_idle) || (r_cnt >= w_thresh));
    assign w_reject  = w_edge && !w_accept;
    assign w_timeout = (r_state != c_st_idle) && (r_cnt == c_timeout) && !w_accept;

    always_comb begin
        w_state_nxt   = r_state;
        w_strobe_nxt  = 1'b0;
        w_period_nxt  = r_period;
        w_valid_nxt   = r_valid;
        w_stalled_nxt = r_stalled;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt  = c_st_first;
                    w_strobe_nxt = 1'b1;
                end
            end
            c_st_first, c_st_run: begin
                if (w_accept) begin
                    w_state_nxt   = c_st_run;
                    w_strobe_nxt  = 1'b1;
                    w_period_nxt  = r_cnt;
                    w_valid_nxt   = 1'b1;
                    w_stalled_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_state_nxt   = c_st_idle;
                    w_period_nxt  = '0;
                    w_valid_nxt   = 1'b0;
                    w_stalled_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = c_st_idle;
                w_period_nxt  = '0;
                w_valid_nxt   = 1'b0;
                w_stalled_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_vr_d    <= vr_in;
            r_cnt     <= '0;
            r_strobe  <= 1'b0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_stalled <= 1'b1;
            r_noise   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vr_d    <= vr_in;
            r_strobe  <= w_strobe_nxt;
            r_period  <= w_period_nxt;
            r_valid   <= w_valid_nxt;
            r_stalled <= w_stalled_nxt;
            if (w_accept) begin
                r_cnt <= c_one;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_one;
            end
            if (w_reject && (r_noise != 16'hFFFF)) begin
                r_noise <= r_noise + 16'd1;
            end
        end
    end

    assign tooth_strobe = r_strobe;
    assign tooth_period = r_period;
    assign period_valid = r_valid;
    assign stalled      = r_stalled;
    assign noise_cnt    = r_noise;

endmodule
`default_nettype wire
